// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// State encoding, default bus width and timeout counter sizing.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 32;

  // A single-cycle budget still needs one counter bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Variable-latency data-memory request/response bus.
// The controller side is the master and the memory side is the slave.
interface dmem_access_ctrl_if
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// Watchdog counter for one outstanding access; expired is high on the
// last permitted BUSY cycle (count == TIMEOUT_CYCLES-1).
module dmem_timeout_cnt
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Count BUSY cycles without a response; cleared while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: sequences loads/stores onto the memory handshake,
// stalls the pipeline while pending. Optional macro ALIGN_CHECK_EN adds addr_err.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemWrite_M,
  input  logic                 MemtoReg_M,
  input  logic [DATA_W-1:0]    ALUOut_M,
  input  logic [DATA_W-1:0]    WriteData_M,
  dmem_access_ctrl_if.master   bus,
  output logic [DATA_W-1:0]    ReadData_M,
  output logic                 stall_M,
  output logic                 bus_err
`ifdef ALIGN_CHECK_EN
  , output logic               addr_err
`endif
);

  state_t            state_r, state_nxt_s;
  logic              mem_req_r, req_nxt_s;
  logic              mem_we_r, we_nxt_s;
  logic [DATA_W-1:0] mem_addr_r, addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_r, wdata_nxt_s;
  logic [DATA_W-1:0] read_data_r, rdata_nxt_s;
  logic              bus_err_r, bus_err_nxt_s;
  logic              stall_s;
  logic              access_pending_s;
  logic              issue_s;
  logic              cnt_clear_s, cnt_en_s, expired_s;

  assign access_pending_s = MemWrite_M | MemtoReg_M;

`ifdef ALIGN_CHECK_EN
  logic addr_err_r, addr_err_nxt_s;
  assign issue_s = access_pending_s & (ALUOut_M[1:0] == 2'b00);
`else
  assign issue_s = access_pending_s;
`endif

  dmem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, stall and next values of the registered bus outputs.
  always_comb begin
    state_nxt_s   = state_r;
    stall_s       = 1'b0;
    req_nxt_s     = mem_req_r;
    we_nxt_s      = mem_we_r;
    addr_nxt_s    = mem_addr_r;
    wdata_nxt_s   = mem_wdata_r;
    rdata_nxt_s   = read_data_r;
    bus_err_nxt_s = 1'b0;
    cnt_clear_s   = 1'b0;
    cnt_en_s      = 1'b0;
`ifdef ALIGN_CHECK_EN
    addr_err_nxt_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        stall_s     = access_pending_s;
        cnt_clear_s = 1'b1;
        if (issue_s) begin
          state_nxt_s = BUSY;
          req_nxt_s   = 1'b1;
          we_nxt_s    = MemWrite_M;
          addr_nxt_s  = ALUOut_M;
          wdata_nxt_s = WriteData_M;
        end
`ifdef ALIGN_CHECK_EN
        else if (access_pending_s) begin
          state_nxt_s    = DONE;
          rdata_nxt_s    = '0;
          addr_err_nxt_s = 1'b1;
        end
`endif
        else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        // A response on the last permitted cycle still wins over the timeout.
        if (bus.mem_ready) begin
          state_nxt_s = DONE;
          req_nxt_s   = 1'b0;
          if (!mem_we_r) begin
            rdata_nxt_s = bus.mem_rdata;
          end else begin
            rdata_nxt_s = read_data_r;
          end
        end else if (expired_s) begin
          state_nxt_s   = DONE;
          req_nxt_s     = 1'b0;
          rdata_nxt_s   = '0;
          bus_err_nxt_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output registers for the memory request and MEM/WB data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      read_data_r <= '0;
      bus_err_r   <= 1'b0;
    end else begin
      mem_req_r   <= req_nxt_s;
      mem_we_r    <= we_nxt_s;
      mem_addr_r  <= addr_nxt_s;
      mem_wdata_r <= wdata_nxt_s;
      read_data_r <= rdata_nxt_s;
      bus_err_r   <= bus_err_nxt_s;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Misalignment pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= addr_err_nxt_s;
    end
  end

  assign addr_err = addr_err_r;
`endif

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign ReadData_M    = read_data_r;
  assign bus_err       = bus_err_r;
  assign stall_M       = stall_s;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (TIMEOUT_CYCLES=16).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite_M = 1'b0;
  logic        MemtoReg_M = 1'b0;
  logic [31:0] ALUOut_M = 32'h0;
  logic [31:0] WriteData_M = 32'h0;
  logic [31:0] ReadData_M;
  logic        stall_M;
  logic        bus_err;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
`endif
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;
  int busy_cnt;

  dmem_access_ctrl_if #(.DATA_W(32)) bus ();

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite_M (MemWrite_M),
    .MemtoReg_M (MemtoReg_M),
    .ALUOut_M   (ALUOut_M),
    .WriteData_M(WriteData_M),
    .bus        (bus),
    .ReadData_M (ReadData_M),
    .stall_M    (stall_M),
`ifdef ALIGN_CHECK_EN
    .addr_err   (addr_err),
`endif
    .bus_err    (bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    smp();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus.mem_req); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    n_checks++; if (ReadData_M !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", ReadData_M); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_buserr got=%b exp=0", bus_err); end
    n_checks++; if (stall_M !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", stall_M); end
    step();
    rst = 1'b1;
    // Non-memory instruction with a stray ready: nothing must happen.
    ALUOut_M = 32'h1234;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    smp();
    n_checks++; if (stall_M !== 1'b0) begin n_fail++; $display("FAIL nomem_stall got=%b exp=0", stall_M); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL nomem_req got=%b exp=0", bus.mem_req); end
    step();
    smp();
    n_checks++; if (ReadData_M !== 32'h0) begin n_fail++; $display("FAIL nomem_rdata got=%h exp=0", ReadData_M); end
    step();
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_load();
    stall_cnt = 0;
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h10;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_idle_req got=%b exp=0", bus.mem_req); end
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL load_req got=%b exp=1", bus.mem_req); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL load_we got=%b exp=0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL load_addr got=%h exp=10", bus.mem_addr); end
    step();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (ReadData_M !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data got=%h exp=deadbeef", ReadData_M); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_done_req got=%b exp=0", bus.mem_req); end
    step();
    MemtoReg_M = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (stall_cnt !== 2) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_store_wait();
    stall_cnt = 0;
    MemWrite_M = 1'b1;
    ALUOut_M = 32'h20;
    WriteData_M = 32'h12345678;
    smp();
    stall_cnt += int'(stall_M);
    for (int k = 0; k < 4; k++) begin
      step();
      MemWrite_M = 1'b0;
      ALUOut_M = 32'hFFFF_FFF0;
      WriteData_M = 32'h0;
      bus.mem_ready = (k == 3);
      bus.mem_rdata = 32'h5A5A5A5A;
      smp();
      stall_cnt += int'(stall_M);
      n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_req_we cyc=%0d got=%b exp=11", k, {bus.mem_req, bus.mem_we}); end
      n_checks++; if (bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL store_hold cyc=%0d got=%h/%h exp=20/12345678", k, bus.mem_addr, bus.mem_wdata); end
      // EX/MEM is frozen while stalled, so restore the store after the probe above.
      MemWrite_M = 1'b1;
      ALUOut_M = 32'h20;
      WriteData_M = 32'h12345678;
    end
    step();
    bus.mem_ready = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (ReadData_M !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_rdata got=%h exp=deadbeef", ReadData_M); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL store_done_req got=%b exp=0", bus.mem_req); end
    step();
    MemWrite_M = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (stall_cnt !== 5) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    stall_cnt = 0;
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h40;
    smp();
    stall_cnt += int'(stall_M);
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hA5A50001;
    smp();
    stall_cnt += int'(stall_M);
    step();
    bus.mem_ready = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (ReadData_M !== 32'hA5A50001) begin n_fail++; $display("FAIL b2b_load_data got=%h exp=a5a50001", ReadData_M); end
    step();
    MemtoReg_M = 1'b0;
    MemWrite_M = 1'b1;
    ALUOut_M = 32'h44;
    WriteData_M = 32'h0BADF00D;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (stall_M !== 1'b1) begin n_fail++; $display("FAIL b2b_second_stall got=%b exp=1", stall_M); end
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h44, 32'h0BADF00D}) begin n_fail++; $display("FAIL b2b_store_req got=%b%b %h %h exp=11 44 0badf00d", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step();
    bus.mem_ready = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (ReadData_M !== 32'hA5A50001) begin n_fail++; $display("FAIL b2b_store_rdata got=%h exp=a5a50001", ReadData_M); end
    step();
    MemWrite_M = 1'b0;
    smp();
    stall_cnt += int'(stall_M);
    n_checks++; if (stall_cnt !== 4) begin n_fail++; $display("FAIL b2b_stall_cycles got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_both_flags();
    MemWrite_M = 1'b1;
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h30;
    WriteData_M = 32'h55;
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77777777;
    smp();
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL both_we got=%b exp=1", bus.mem_we); end
    step();
    bus.mem_ready = 1'b0;
    smp();
    n_checks++; if (ReadData_M !== 32'hA5A50001) begin n_fail++; $display("FAIL both_rdata got=%h exp=a5a50001", ReadData_M); end
    step();
    MemWrite_M = 1'b0;
    MemtoReg_M = 1'b0;
  endtask

  task automatic test_timeout();
    busy_cnt = 0;
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h80;
    smp();
    for (int i = 0; i < 40; i++) begin
      step();
      smp();
      if (bus.mem_req === 1'b1) busy_cnt++;
      else break;
    end
    n_checks++; if (busy_cnt !== 16) begin n_fail++; $display("FAIL timeout_busy_cycles got=%0d exp=16", busy_cnt); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_buserr got=%b exp=1", bus_err); end
    n_checks++; if (ReadData_M !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata got=%h exp=0", ReadData_M); end
    n_checks++; if (stall_M !== 1'b0) begin n_fail++; $display("FAIL timeout_stall got=%b exp=0", stall_M); end
    step();
    MemtoReg_M = 1'b0;
    smp();
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got=%b exp=0", bus_err); end
  endtask

  task automatic test_reset_mid_access();
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h100;
    step();
    smp();
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got=%b exp=1", bus.mem_req); end
    #2;
    rst = 1'b0;
    MemtoReg_M = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got=%b exp=0", bus.mem_req); end
    n_checks++; if (stall_M !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got=%b exp=0", stall_M); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got=%h exp=0", bus.mem_addr); end
    step();
    step();
    rst = 1'b1;
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h104;
    smp();
    n_checks++; if ({stall_M, bus.mem_req} !== 2'b10) begin n_fail++; $display("FAIL midrst_idle got=%b exp=10", {stall_M, bus.mem_req}); end
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0F0F0F0F;
    smp();
    n_checks++; if (bus.mem_addr !== 32'h104) begin n_fail++; $display("FAIL midrst_new_addr got=%h exp=104", bus.mem_addr); end
    step();
    bus.mem_ready = 1'b0;
    smp();
    n_checks++; if (ReadData_M !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL midrst_new_data got=%h exp=0f0f0f0f", ReadData_M); end
    step();
    MemtoReg_M = 1'b0;
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_misaligned();
    MemtoReg_M = 1'b1;
    ALUOut_M = 32'h13;
    smp();
    n_checks++; if ({stall_M, bus.mem_req} !== 2'b10) begin n_fail++; $display("FAIL align_idle got=%b exp=10", {stall_M, bus.mem_req}); end
    step();
    smp();
    n_checks++; if ({addr_err, bus.mem_req, stall_M} !== 3'b100) begin n_fail++; $display("FAIL align_done got=%b exp=100", {addr_err, bus.mem_req, stall_M}); end
    n_checks++; if (ReadData_M !== 32'h0) begin n_fail++; $display("FAIL align_rdata got=%h exp=0", ReadData_M); end
    step();
    MemtoReg_M = 1'b0;
    smp();
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL align_pulse got=%b exp=0", addr_err); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_both_flags();
    test_timeout();
    test_reset_mid_access();
`ifdef ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Memory-stage controller that sequences data-memory loads and stores issued by the EX/MEM pipeline register onto a variable-latency memory handshake. It drives a stall that freezes all pipeline registers up to and including EX/MEM while an access is outstanding. It captures load data for the MEM/WB register and bounds every access with a timeout watchdog.

Parameters:
- DATA_W, 32, data/address width
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before an access is aborted (>=1)

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-low reset
- MemWrite_M, input, 1, store in MEM stage
- MemtoReg_M, input, 1, load in MEM stage
- ALUOut_M, input, DATA_W, byte address
- WriteData_M, input, DATA_W, store data
- mem_req, output, 1, request to data memory
- mem_we, output, 1, 1=write, 0=read
- mem_addr, output, DATA_W, request address
- mem_wdata, output, DATA_W, request write data
- mem_ready, input, 1, memory completes the request this cycle
- mem_rdata, input, DATA_W, read data, valid with mem_ready
- ReadData_M, output, DATA_W, captured load data for MEM/WB
- stall_M, output, 1, freeze F/D/E/M pipeline registers
- bus_err, output, 1, one-cycle pulse: access timed out

Behaviour:
- Reset is clk/rst: async active-low. On reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData_M=0, bus_err=0, timeout count=0. stall_M=0 because there is no pending access in IDLE after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access_pending = MemWrite_M | MemtoReg_M.
  - stall_M = access_pending, combinational, in the same cycle.
  - If access_pending, on the next edge go to BUSY. Register mem_req=1, mem_we=MemWrite_M, mem_addr=ALUOut_M, mem_wdata=WriteData_M, and clear the counter.
- BUSY:
  - stall_M=1. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - If mem_ready=1: mem_req<=0. For a read, ReadData_M<=mem_rdata; for a write, ReadData_M is unchanged. Go to DONE.
  - Else the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without mem_ready: mem_req<=0, ReadData_M<=0, bus_err<=1 for one cycle, go to DONE.
- DONE:
  - stall_M=0, so the pipeline advances at this edge. Next state is IDLE.
  - mem_ready seen in DONE or IDLE is ignored.
- Latency: a zero-wait access (mem_ready in the first BUSY cycle) stalls for 2 cycles. Each extra wait cycle adds 1 stall cycle.
- Back-to-back memory instructions: the next one enters MEM at the DONE->IDLE edge and is serviced from IDLE with no lost cycle.
- MemWrite_M=1 and MemtoReg_M=1 together: treated as a store. No load data is captured.
- Reset asserted mid-access (BUSY): mem_req drops immediately and the access is abandoned. The memory must tolerate a withdrawn request.
- Non-memory instructions: stall_M=0 and mem_req=0. No effect on the pipeline.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- When defined:
  - Adds output port addr_err (1 bit).
  - In IDLE, if access_pending and ALUOut_M[1:0]!=0, no request is issued. The FSM goes directly to DONE, addr_err pulses for 1 cycle, ReadData_M<=0, and the stall lasts 1 cycle.
- When undefined: the port is absent and all addresses are passed to the memory unchanged.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Default DATA_W.
  - Counter width function (clog2 of TIMEOUT_CYCLES).
- One natural sub-module: dmem_timeout_cnt.
  - Inputs: clear, enable.
  - Output: expired.
  - Instanced once; the FSM stays in the top block.

Test Plan:
- Load at addr 0x10, mem_ready in 1st BUSY cycle with rdata 0xDEADBEEF:
  - stall_M high 2 cycles.
  - mem_req high 1 cycle, mem_we=0, mem_addr=0x10.
  - ReadData_M=0xDEADBEEF in DONE.
- Store 0x12345678 to 0x20, mem_ready after 3 wait cycles:
  - mem_we=1, addr/wdata stable for all 4 BUSY cycles.
  - stall_M high 5 cycles.
  - ReadData_M unchanged.
- Back-to-back load then store:
  - Second request starts in the cycle after DONE.
  - No extra idle cycle; total stall 4 cycles.
- mem_ready never asserted, TIMEOUT_CYCLES=16:
  - mem_req drops after 16 BUSY cycles.
  - bus_err pulses once, ReadData_M=0, pipeline resumes.
- rst low during BUSY:
  - mem_req, stall_M and state are cleared asynchronously.
  - After release, a new load completes normally.
- ALIGN_CHECK_EN defined, load at 0x13:
  - addr_err pulses 1 cycle, mem_req stays 0.
  - stall_M high 1 cycle, ReadData_M=0.
